ook_frame_receiver: RTL and testbench

// Downstream consumer of the min/max carrier detector. Takes the detector's per-sample
// "transmission present" level and the ADC sample strobe, and recovers UART-style frames:
// 1 start, DATA_BITS data bits (LSB first), 1 stop. Carrier present = 1, idle = 0.

---
 rtl/ook_frame_receiver.sv | 162 ++++++++++++++++
 tb/tb_ook_frame_receiver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ook_frame_receiver.sv
// OOK frame receiver: recovers UART-style frames (start, LSB-first data,
// stop) from the carrier detector's per-sample "transmission present" level.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   axiiv          sample strobe; all bit timing counts these strobes
//   triggered      carrier level, sampled only on strobes
//   axiov          one-cycle pulse, axiod holds a good frame
//   axiod          received word, held until the next axiov
//   framing_error  one-cycle pulse, stop bit read as 1 (word dropped)
//   busy           receiver is inside a frame (state != IDLE)
//   err_count      saturating framing error count since reset
module ook_frame_receiver #(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 axiiv,
    input  logic                 triggered,
    output logic                 axiov,
    output logic [DATA_BITS-1:0] axiod,
    output logic                 framing_error,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int HALF = SAMPLES_PER_BIT / 2;
    localparam int CW   = $clog2(SAMPLES_PER_BIT) + 1;
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_C   = CW'(HALF);
    localparam logic [CW-1:0] SPB_C    = CW'(SAMPLES_PER_BIT);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_inc, cnt_nx;
    logic [BW-1:0]        bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 good_nx, bad_nx;

    assign cnt_inc = cnt + 1'b1;

    // State register together with the frame datapath it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
        end
    end

    // Next-state logic. cnt holds strobes since the last sample point, so
    // cnt_inc is the position of the strobe being accepted now: START
    // samples mid-bit at HALF, later bits one full period apart.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        good_nx    = 1'b0;
        bad_nx     = 1'b0;
        if (axiiv) begin
            unique case (state)
                S_IDLE: begin
                    if (triggered) begin
                        state_nx   = S_START;
                        cnt_nx     = '0;
                        bit_idx_nx = '0;
                    end
                end
                S_START: begin
                    if (cnt_inc == HALF_C) begin
                        cnt_nx   = '0;
                        state_nx = triggered ? S_DATA : S_IDLE;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                S_DATA: begin
                    if (cnt_inc == SPB_C) begin
                        cnt_nx   = '0;
                        // LSB first: new bit enters at the top, so after
                        // the last bit the first one sits in bit 0.
                        shreg_nx = shreg >> 1;
                        shreg_nx[DATA_BITS-1] = triggered;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx_nx = '0;
                            state_nx   = S_STOP;
                        end else begin
                            bit_idx_nx = bit_idx + 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                S_STOP: begin
                    if (cnt_inc == SPB_C) begin
                        cnt_nx = '0;
                        if (triggered) begin
                            bad_nx   = 1'b1;
                            state_nx = S_WAIT;
                        end else begin
                            good_nx  = 1'b1;
                            state_nx = S_IDLE;
                        end
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                S_WAIT: begin
                    // A carrier still on after a bad stop must drop before
                    // a new start can be recognised.
                    if (!triggered) begin
                        state_nx = S_IDLE;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Output logic.
    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            axiov         <= 1'b0;
            framing_error <= 1'b0;
            axiod         <= '0;
            err_count     <= '0;
        end else begin
            axiov         <= good_nx;
            framing_error <= bad_nx;
            if (good_nx) begin
                axiod <= shreg;
            end
            if (bad_nx && (err_count != 8'hFF)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ook_frame_receiver.sv
// Self-checking bench for ook_frame_receiver: strobe-level streams are
// decoded by a frame-level reference model and compared per strobe.
module tb_ook_frame_receiver;

    localparam int SPB  = 16;
    localparam int DB   = 8;
    localparam int HALF = SPB / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          axiiv;
    logic          triggered;
    logic          axiov;
    logic [DB-1:0] axiod;
    logic          framing_error;
    logic          busy;
    logic [7:0]    err_count;

    int checks   = 0;
    int failures = 0;

    bit         lv[$];
    int         ev_t[$];
    logic [7:0] ev_d[$];
    bit         bz[$];
    int         n_ok;
    int         n_err;
    logic [7:0] last_d;

    ook_frame_receiver #(
        .SAMPLES_PER_BIT(SPB),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .axiiv(axiiv),
        .triggered(triggered),
        .axiov(axiov),
        .axiod(axiod),
        .framing_error(framing_error),
        .busy(busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_lvl(input bit v, input int n);
        repeat (n) lv.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit stop_v,
                              input int stop_n);
        push_lvl(1'b1, SPB);
        for (int b = 0; b < DB; b++) push_lvl(d[b], SPB);
        push_lvl(stop_v, stop_n);
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int k = a; k <= b && k < bz.size(); k++) bz[k] = 1'b1;
    endtask

    // Frame-level decode of the whole strobe stream: find a start, vet it
    // mid-bit, read bits at bit centres, judge the stop bit.
    task automatic build_model();
        int n;
        int i;
        int s;
        int e;
        int stp;
        int k;
        logic [7:0] w;
        n = lv.size();
        ev_t = {};
        ev_d = {};
        bz   = {};
        for (int j = 0; j < n; j++) begin
            ev_t.push_back(0);
            ev_d.push_back(8'h00);
            bz.push_back(1'b0);
        end
        i = 0;
        while (i < n) begin
            if (!lv[i]) begin
                i++;
                continue;
            end
            s = i;
            e = s + HALF;
            if (e >= n) begin
                mark_busy(s, n - 1);
                break;
            end
            if (!lv[e]) begin
                mark_busy(s, e - 1);
                i = e + 1;
                continue;
            end
            stp = s + HALF + (DB + 1) * SPB;
            if (stp >= n) begin
                mark_busy(s, n - 1);
                break;
            end
            w = '0;
            for (int b = 0; b < DB; b++) w[b] = lv[s + HALF + (b + 1) * SPB];
            if (!lv[stp]) begin
                ev_t[stp] = 1;
                ev_d[stp] = w;
                mark_busy(s, stp - 1);
                i = stp + 1;
            end else begin
                ev_t[stp] = 2;
                k = stp + 1;
                while (k < n && lv[k]) k++;
                mark_busy(s, k - 1);
                i = k + 1;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        axiiv     = 1'b0;
        triggered = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_axiov", 32'(axiov), 0);
        check("rst_axiod", 32'(axiod), 0);
        check("rst_fe", 32'(framing_error), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_errcnt", 32'(err_count), 0);
    endtask

    // mode 0: strobe every cycle; 1: every 3rd cycle with noise on
    // triggered between strobes; 2: random gaps.
    task automatic run_stream(input int mode);
        int gap;
        build_model();
        n_ok   = 0;
        n_err  = 0;
        last_d = 8'h00;
        for (int i = 0; i < lv.size(); i++) begin
            gap = (mode == 0) ? 0 : (mode == 1) ? 2 : $urandom_range(0, 3);
            repeat (gap) begin
                axiiv     = 1'b0;
                triggered = 1'($urandom);
                @(posedge clk);
                #1;
                check("gap_axiov", 32'(axiov), 0);
                check("gap_fe", 32'(framing_error), 0);
            end
            axiiv     = 1'b1;
            triggered = lv[i];
            @(posedge clk);
            #1;
            check("axiov", 32'(axiov), 32'(ev_t[i] == 1));
            check("fe", 32'(framing_error), 32'(ev_t[i] == 2));
            check("busy", 32'(busy), 32'(bz[i]));
            if (ev_t[i] == 1) begin
                n_ok++;
                last_d = ev_d[i];
                check("axiod", 32'(axiod), 32'(last_d));
            end
            if (ev_t[i] == 2) n_err++;
        end
        axiiv     = 1'b0;
        triggered = 1'b0;
        @(posedge clk);
        #1;
        check("end_axiov", 32'(axiov), 0);
        check("end_fe", 32'(framing_error), 0);
        check("end_axiod", 32'(axiod), 32'(last_d));
        check("end_errcnt", 32'(err_count), 32'((n_err > 255) ? 255 : n_err));
    endtask

    initial begin
        int k;
        do_reset();

        // Basic frame after idle.
        lv = {};
        push_lvl(1'b0, 40);
        push_frame(8'hA5, 1'b0, SPB);
        run_stream(0);
        check("t1_pulses", 32'(n_ok), 1);
        check("t1_errs", 32'(n_err), 0);
        check("t1_axiod", 32'(axiod), 32'h0A5);
        check("t1_busy", 32'(busy), 0);

        // Short glitch.
        do_reset();
        lv = {};
        push_lvl(1'b1, 4);
        push_lvl(1'b0, 20);
        run_stream(0);
        check("t2_pulses", 32'(n_ok + n_err), 0);
        check("t2_busy_s8", 32'(bz[8]), 0);

        // Framing error with long carrier, then good frame.
        do_reset();
        lv = {};
        push_lvl(1'b0, 3);
        push_frame(8'h3C, 1'b1, 40);
        push_lvl(1'b0, 5);
        push_frame(8'h11, 1'b0, SPB);
        run_stream(0);
        check("t3_errs", 32'(n_err), 1);
        check("t3_errcnt", 32'(err_count), 1);
        check("t3_ok", 32'(n_ok), 1);
        check("t3_axiod", 32'(axiod), 32'h011);

        // Back-to-back frames.
        do_reset();
        lv = {};
        push_frame(8'h00, 1'b0, SPB);
        push_lvl(1'b0, 1);
        push_frame(8'hFF, 1'b0, SPB);
        run_stream(0);
        check("t4_ok", 32'(n_ok), 2);
        check("t4_axiod", 32'(axiod), 32'h0FF);

        // Reset in data bit 4, then a clean frame.
        do_reset();
        lv = {};
        push_lvl(1'b1, SPB);
        for (int b = 0; b < 4; b++) push_lvl(b[0] ? 1'b1 : 1'b0, SPB);
        push_lvl(1'b0, HALF + 2);
        run_stream(0);
        check("t5_busy_pre", 32'(busy), 1);
        do_reset();
        lv = {};
        push_frame(8'h5A, 1'b0, SPB);
        run_stream(0);
        check("t5_ok", 32'(n_ok), 1);
        check("t5_axiod", 32'(axiod), 32'h05A);

        // Sparse strobes with noise between them.
        do_reset();
        lv = {};
        push_lvl(1'b0, 40);
        push_frame(8'hA5, 1'b0, SPB);
        run_stream(1);
        check("t6_ok", 32'(n_ok), 1);
        check("t6_axiod", 32'(axiod), 32'h0A5);

        // Random mixes of good, bad, glitch and idle segments.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            lv = {};
            push_lvl(1'b0, $urandom_range(1, 10));
            repeat (5) begin
                k = $urandom_range(0, 3);
                case (k)
                    0: begin
                        push_frame(8'($urandom), 1'b0,
                                   $urandom_range(HALF + 1, SPB + 3));
                        push_lvl(1'b0, $urandom_range(0, 3));
                    end
                    1: begin
                        push_frame(8'($urandom), 1'b1,
                                   $urandom_range(HALF + 1, 40));
                        push_lvl(1'b0, $urandom_range(1, 4));
                    end
                    2: begin
                        push_lvl(1'b1, $urandom_range(1, HALF));
                        push_lvl(1'b0, HALF + 1);
                    end
                    default: push_lvl(1'b0, $urandom_range(1, 20));
                endcase
            end
            push_lvl(1'b0, 2 * SPB);
            run_stream($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
